// File: rtl/hazard_unit_pkg.sv
//==============================================================================
// hazard_unit_pkg
// Shared CPU pipeline definitions: hazard-FSM state encodings, counter widths
// and forwarding mux-select encodings.
// Revision: 1.0
//==============================================================================
`default_nettype none

package hazard_unit_pkg;

  // Hazard-control FSM states
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_t;

  // Counter widths
  localparam int WAIT_CNT_W = 8;
  localparam int PERF_CNT_W = 16;

  // Forwarding mux selects used by the execute-stage operand muxes
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_XM   = 2'd1,
    FWD_MW   = 2'd2
  } fwd_sel_t;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
//==============================================================================
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Revision: 1.0
//==============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count up on request, hold once every bit is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
//==============================================================================
// hazard_unit
// Pipeline hazard controller: load-use stall, taken-branch flush and
// data-memory wait freeze, with a sticky wait-timeout flag and saturating
// stall/flush performance counters.
// Revision: 1.0
//==============================================================================
`default_nettype none

module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_addr_fd,
  input  logic [4:0]  rt_addr_fd,
  input  logic        uses_rt_fd,
  input  logic        mem_read_dx,
  input  logic [4:0]  write_reg_addr_dx,
  input  logic        branch_taken_xm,
  input  logic        dmem_req_xm,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        mw_flush,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  hz_state_t             r_state;
  hz_state_t             w_next;
  logic [WAIT_CNT_W-1:0] r_wait;
  logic [WAIT_CNT_W-1:0] w_wait_inc;
  logic                  r_timeout;
  logic                  w_memwait;
  logic                  w_loaduse;
  logic                  w_freeze;
  logic                  w_ld_stall;
  logic                  w_br_flush;
  logic                  w_wait_clr;

  assign w_memwait  = dmem_req_xm && !dmem_ready;
  // $0 is hard-wired zero, so a load targeting it never creates a hazard
  assign w_loaduse  = mem_read_dx && (write_reg_addr_dx != 5'd0) &&
                      ((write_reg_addr_dx == rs_addr_fd) ||
                       (uses_rt_fd && (write_reg_addr_dx == rt_addr_fd)));
  assign w_wait_inc = (r_wait == {WAIT_CNT_W{1'b1}}) ? r_wait : r_wait + WAIT_CNT_W'(1);

  // Next state and hazard actions; priority memwait > branch > load-use
  always_comb begin
    w_next     = RUN;
    w_freeze   = 1'b0;
    w_ld_stall = 1'b0;
    w_br_flush = 1'b0;
    w_wait_clr = 1'b0;
    if (r_state == MEM_WAIT) begin
      if (!dmem_ready) begin
        w_freeze = 1'b1;
        w_next   = MEM_WAIT;
      end else begin
        // Leaving the wait: branch still honoured, load-use deliberately not
        w_wait_clr = 1'b1;
        w_br_flush = branch_taken_xm;
      end
    end else if (w_memwait) begin
      w_freeze = 1'b1;
      w_next   = MEM_WAIT;
    end else if (branch_taken_xm) begin
      w_br_flush = 1'b1;
    end else if (w_loaduse && (r_state == RUN)) begin
      // LOAD_STALL masks load-use so the stall lasts exactly one cycle
      w_ld_stall = 1'b1;
      w_next     = LOAD_STALL;
    end
    // Reset forces default controls immediately, without waiting for clk
    if (!rst) begin
      w_freeze   = 1'b0;
      w_ld_stall = 1'b0;
      w_br_flush = 1'b0;
    end
  end

  assign pc_en    = !(w_freeze || w_ld_stall);
  assign fd_en    = !(w_freeze || w_ld_stall);
  assign dx_en    = !w_freeze;
  assign xm_en    = !w_freeze;
  assign fd_flush = w_br_flush;
  assign dx_flush = w_br_flush || w_ld_stall;
  assign mw_flush = w_freeze;

  // State register, memory-wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wait_clr) begin
        r_wait <= '0;
      end else if (w_freeze) begin
        r_wait <= w_wait_inc;
        if (32'(w_wait_inc) >= MEM_TIMEOUT) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign mem_timeout = r_timeout;

  sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_inc   (!pc_en),
    .o_count (stall_cycles)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_inc   (w_br_flush),
    .o_count (flush_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
//==============================================================================
// tb_hazard_unit
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of the hazard rules.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_hazard_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs_addr_fd = '0;
  logic [4:0]  rt_addr_fd = '0;
  logic        uses_rt_fd = 1'b0;
  logic        mem_read_dx = 1'b0;
  logic [4:0]  write_reg_addr_dx = '0;
  logic        branch_taken_xm = 1'b0;
  logic        dmem_req_xm = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_en, fd_en, dx_en, xm_en;
  logic        fd_flush, dx_flush, mw_flush;
  logic        mem_timeout;
  logic [15:0] stall_cycles, flush_count;

  hazard_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .rs_addr_fd        (rs_addr_fd),
    .rt_addr_fd        (rt_addr_fd),
    .uses_rt_fd        (uses_rt_fd),
    .mem_read_dx       (mem_read_dx),
    .write_reg_addr_dx (write_reg_addr_dx),
    .branch_taken_xm   (branch_taken_xm),
    .dmem_req_xm       (dmem_req_xm),
    .dmem_ready        (dmem_ready),
    .pc_en             (pc_en),
    .fd_en             (fd_en),
    .dx_en             (dx_en),
    .xm_en             (xm_en),
    .fd_flush          (fd_flush),
    .dx_flush          (dx_flush),
    .mw_flush          (mw_flush),
    .mem_timeout       (mem_timeout),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Output vector order: {pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush, mw_flush}
  localparam logic [6:0] V_DEF    = 7'b1111_000;
  localparam logic [6:0] V_LDST   = 7'b0011_010;
  localparam logic [6:0] V_FREEZE = 7'b0000_001;
  localparam logic [6:0] V_BRANCH = 7'b1111_110;

  // Behavioural model: "waiting on memory", "stalled last cycle", run length
  bit         m_waiting, m_stalled, m_to;
  int         m_waitlen, m_stall, m_flush;
  bit         e_freeze, e_ld, e_br;
  logic [6:0] e_vec, obs_vec;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_stalled = 0; m_to = 0;
    m_waitlen = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_eval();
    bit mw, lu;
    mw = dmem_req_xm && !dmem_ready;
    lu = mem_read_dx && (write_reg_addr_dx != 0) &&
         ((write_reg_addr_dx == rs_addr_fd) || (uses_rt_fd && (write_reg_addr_dx == rt_addr_fd)));
    e_freeze = 0; e_ld = 0; e_br = 0;
    if (m_waiting) begin
      if (!dmem_ready) e_freeze = 1;
      else             e_br = branch_taken_xm;
    end else if (mw)              e_freeze = 1;
    else if (branch_taken_xm)     e_br = 1;
    else if (lu && !m_stalled)    e_ld = 1;
    e_vec = e_freeze ? V_FREEZE : e_ld ? V_LDST : e_br ? V_BRANCH : V_DEF;
  endtask

  task automatic model_clock();
    if (e_freeze) begin
      if (m_waitlen < 255) m_waitlen++;
      if (m_waitlen >= TO) m_to = 1;
    end
    if (m_waiting && dmem_ready) m_waitlen = 0;
    if ((e_freeze || e_ld) && m_stall < 65535) m_stall++;
    if (e_br && m_flush < 65535) m_flush++;
    m_waiting = e_freeze;
    m_stalled = e_ld;
  endtask

  // One cycle: apply inputs at posedge+1, sample outputs at posedge+4,
  // sample registered results at the next posedge+1.
  task automatic step(input bit mr, input int wr, input int rs, input int rt, input bit urt,
                      input bit br, input bit req, input bit rdy);
    mem_read_dx = mr; write_reg_addr_dx = 5'(wr);
    rs_addr_fd = 5'(rs); rt_addr_fd = 5'(rt); uses_rt_fd = urt;
    branch_taken_xm = br; dmem_req_xm = req; dmem_ready = rdy;
    #3;
    model_eval();
    obs_vec = {pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush, mw_flush};
    chk("ctrl_outputs", 32'(obs_vec), 32'(e_vec));
    @(posedge clk);
    model_clock();
    #1;
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("flush_count", 32'(flush_count), 32'(m_flush));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset state
    #2;
    chk("reset_outputs", 32'({pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush, mw_flush}), 32'(V_DEF));
    chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Load into r5, FD reads rs=5: one stall cycle, then defaults
    step(1, 5, 5, 0, 0, 0, 0, 0);
    chk("lu_stall_vec", 32'(obs_vec), 32'(V_LDST));
    step(1, 5, 5, 0, 0, 0, 0, 0);
    chk("lu_release_vec", 32'(obs_vec), 32'(V_DEF));
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // $0 never stalls; rt ignored when not used
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_no_stall", 32'(obs_vec), 32'(V_DEF));
    step(1, 7, 1, 7, 0, 0, 0, 0);
    chk("rt_unused_no_stall", 32'(obs_vec), 32'(V_DEF));

    // Memory wait of 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0);
      chk("memwait_freeze", 32'(obs_vec), 32'(V_FREEZE));
    end
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("memwait_release", 32'(obs_vec), 32'(V_DEF));
    chk("memwait_stall_cnt", 32'(stall_cycles), 32'd4);
    chk("memwait_no_timeout", 32'(mem_timeout), 32'd0);

    // Branch and load-use together: branch wins, state stays RUN
    step(1, 5, 5, 0, 0, 1, 0, 0);
    chk("br_over_lu_vec", 32'(obs_vec), 32'(V_BRANCH));
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    step(1, 5, 5, 0, 0, 0, 0, 0);
    chk("after_br_in_run", 32'(obs_vec), 32'(V_LDST));
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Timeout: flag rises after the 4th wait cycle and stays set
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0);
      chk("timeout_progress", 32'(mem_timeout), (i >= TO) ? 32'd1 : 32'd0);
    end
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("timeout_sticky_release", 32'(mem_timeout), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout_sticky_idle", 32'(mem_timeout), 32'd1);

    // Reset pulsed mid-wait: defaults and zeroed counters without a clock edge
    step(0, 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_wait_outputs", 32'({pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush, mw_flush}), 32'(V_DEF));
    chk("rst_mid_wait_stall", 32'(stall_cycles), 32'd0);
    chk("rst_mid_wait_flush", 32'(flush_count), 32'd0);
    chk("rst_mid_wait_timeout", 32'(mem_timeout), 32'd0);
    rst = 1'b1;
    model_reset();
    step(1, 3, 0, 3, 1, 0, 0, 0);
    chk("post_rst_lu_stall", 32'(obs_vec), 32'(V_LDST));

    // Random traffic with small register ranges to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: the number of memory-wait cycles after which mem_timeout is raised.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports rs_addr_fd, rt_addr_fd  input  5 each  source register numbers of the instruction in the FD stage.
REQ-005 SHALL have port uses_rt_fd  input  1  high when the FD instruction reads rt.
REQ-006 SHALL have ports mem_read_dx  input  1  and write_reg_addr_dx  input  5  which identify a load in the DX stage and its destination register.
REQ-007 SHALL have port branch_taken_xm  input  1  which signals a resolved taken branch in the XM stage.
REQ-008 SHALL have ports dmem_req_xm  input  1  and dmem_ready  input  1  which form the data-memory request/ready handshake for the XM stage.
REQ-009 SHALL have ports pc_en, fd_en, dx_en, xm_en  output  1 each  pipeline-register load enables.
REQ-010 SHALL have ports fd_flush, dx_flush, mw_flush  output  1 each  bubble-insert controls.
REQ-011 SHALL have port mem_timeout  output  1  sticky wait-timeout flag.
REQ-012 SHALL have ports stall_cycles, flush_count  output  16 each  saturating performance counters.

Function
REQ-013 SHALL implement an FSM with states RUN, LOAD_STALL and MEM_WAIT; the control outputs are combinational from the current state and the inputs.
REQ-014 SHALL use these defaults in every state: all enables = 1 and all flushes = 0.
REQ-015 SHALL define memwait = dmem_req_xm && !dmem_ready.
REQ-016 SHALL define loaduse = mem_read_dx && write_reg_addr_dx != 0 && (write_reg_addr_dx == rs_addr_fd || (uses_rt_fd && write_reg_addr_dx == rt_addr_fd)).
REQ-017 SHALL apply this priority in every state: memwait > branch_taken_xm > loaduse.
REQ-018 SHALL, on memwait in any state: drive pc_en = fd_en = dx_en = xm_en = 0 and mw_flush = 1, and go to MEM_WAIT.
REQ-019 SHALL, in MEM_WAIT while dmem_ready = 0: hold the freeze outputs and increment the 8-bit wait counter, which saturates at 255.
REQ-020 SHALL, in MEM_WAIT when dmem_ready = 1: drive default outputs, apply the branch flush if branch_taken_xm, clear the wait counter and go to RUN.
REQ-021 SHALL NOT apply load-use detection in the cycle the pipeline leaves MEM_WAIT.
REQ-022 SHALL, on branch_taken_xm without memwait: drive fd_flush = dx_flush = 1 for that cycle, keep enables at 1, go to RUN, and override any loaduse in the same cycle.
REQ-023 SHALL, in RUN on loaduse alone: drive pc_en = fd_en = 0 and dx_flush = 1, and go to LOAD_STALL.
REQ-024 SHALL, in LOAD_STALL: mask loaduse, drive default outputs (unless memwait or branch applies), and go to RUN, so a load-use stall lasts exactly one cycle.
REQ-025 SHALL set mem_timeout when the wait counter reaches MEM_TIMEOUT; the flag stays set until reset and the wait continues.
REQ-026 SHALL increment stall_cycles in every cycle with pc_en = 0, saturating at 16'hFFFF.
REQ-027 SHALL increment flush_count once per applied branch flush, saturating at 16'hFFFF.
REQ-028 SHALL give register $0 no hazard: a load into $0 never stalls.

Reset
REQ-029 SHALL, on rst low and regardless of clk: set state = RUN, wait counter = 0, mem_timeout = 0, stall_cycles = 0 and flush_count = 0.
REQ-030 SHALL hold all enables at 1 and all flushes at 0 while rst is low.
REQ-031 SHALL resume from RUN with zeroed counters and no pending stall after reset is asserted mid-stall or mid-wait.

Structure
REQ-032 SHALL keep the state encodings (RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2) and the counter widths in the shared CPU package alongside the forwarding mux-select encodings.
REQ-033 SHALL have no mandatory sub-module; a saturating counter, sat_counter, parameterised on width, is the natural sub-module and is instantiated for both perf counters.

Verification
REQ-034 SHALL be verified by: load into r5 in DX, FD reads rs = 5 -> one cycle pc_en = fd_en = 0 and dx_flush = 1, next cycle defaults, stall_cycles = 1.
REQ-035 SHALL be verified by: load into r0 with rs_fd = 0 -> no stall; load into r7 with rt_fd = 7 and uses_rt_fd = 0 -> no stall.
REQ-036 SHALL be verified by: dmem_req_xm = 1 with dmem_ready low for 3 cycles -> freeze for 3 cycles with mw_flush = 1, release on the 4th cycle, stall_cycles = 3.
REQ-037 SHALL be verified by: branch_taken_xm and loaduse in the same cycle -> fd_flush = dx_flush = 1, pc_en = 1, flush_count = 1, state stays RUN.
REQ-038 SHALL be verified by: MEM_TIMEOUT = 4 with dmem_ready held low for 6 cycles -> mem_timeout rises on cycle 4 and stays high after dmem_ready.
REQ-039 SHALL be verified by: rst pulsed low during MEM_WAIT -> outputs return to defaults immediately without a clk edge, and counters and mem_timeout read 0.
